// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACK    = 2'd2,
    WAIT   = 2'd3
  } arb_state_t;

  // Index width for n requesters; never zero so a 1-bit index is always available.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first request strictly after
// i_last, wrapping, so the previous winner has the lowest priority.
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [GW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    logic [GW:0] v_pos;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    v_pos = '0;
    // One extra bit holds i_last + k before the wrap, which stays below 2*N.
    for (int k = 1; k <= N; k++) begin
      v_pos = {1'b0, i_last} + (GW+1)'(k);
      if (v_pos >= (GW+1)'(N)) begin
        v_pos = v_pos - (GW+1)'(N);
      end
      if (!o_any && i_req[v_pos[GW-1:0]]) begin
        o_any                  = 1'b1;
        o_gnt[v_pos[GW-1:0]]   = 1'b1;
        o_idx                  = v_pos[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers.
// Build option UART_ARB_LOCK_EN: stay on one requester until its last-of-packet byte completes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_W  = DATA_W_DEF,
  parameter int  CNT_W   = 16,
  localparam int GW      = grant_w(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_byte2send,
  output logic                      o_tx_start,
  input  logic                      i_tx_done,
  output logic [GW-1:0]             o_grant_id,
  output logic                      o_busy,
  output logic [CNT_W-1:0]          o_tx_count
);

  // state  | meaning
  // IDLE   | pick a requester and accept its byte in the same cycle
  // LAUNCH | tx_start high for this single cycle
  // ACK    | wait for tx_done low, i.e. the transmitter has started shifting
  // WAIT   | wait for tx_done high, i.e. the frame is finished

  arb_state_t          r_state;
  logic [DATA_W-1:0]   r_byte2send;
  logic                r_tx_start;
  logic                r_busy;
  logic [GW-1:0]       r_grant_id;
  logic [CNT_W-1:0]    r_tx_count;

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [GW-1:0]       w_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign w_bytes[i] = i_req_data[i*DATA_W +: DATA_W];
  end

`ifdef UART_ARB_LOCK_EN
  logic r_lock;
  // While locked only the owner of the open packet may be picked.
  assign w_req = r_lock ? (i_req_valid & (NUM_REQ'(1) << r_grant_id)) : i_req_valid;
`else
  logic w_unused_last;
  assign w_unused_last = ^i_req_last;
  assign w_req         = i_req_valid;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_pick (
    .i_req  (w_req),
    .i_last (r_grant_id),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_byte2send <= '0;
      r_tx_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_id  <= GW'(NUM_REQ - 1);
      r_tx_count  <= '0;
`ifdef UART_ARB_LOCK_EN
      r_lock      <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_byte2send <= w_bytes[w_idx];
            r_grant_id  <= w_idx;
            r_tx_start  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= LAUNCH;
`ifdef UART_ARB_LOCK_EN
            r_lock      <= ~i_req_last[w_idx];
`endif
          end
        end
        LAUNCH: r_state <= ACK;
        // A tx_done still high from the previous frame must not count as completion.
        ACK: begin
          if (!i_tx_done) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_tx_done) begin
            r_tx_count <= r_tx_count + CNT_W'(1);
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign o_byte2send = r_byte2send;
  assign o_tx_start  = r_tx_start;
  assign o_grant_id  = r_grant_id;
  assign o_busy      = r_busy;
  assign o_tx_count  = r_tx_count;

endmodule
